rr_arb4: RTL and testbench

Four-channel round-robin arbiter with a registered output stage. It sits directly upstream of the 4:1 select datapath. Up to four requesters present w-bit words with valid flags. Each cycle the block picks one fairly, drives the 2-bit select `s` to the mux datapath, and registers the chosen word into a single valid/ready output slot for the downstream consumer.

---
 rtl/rr_arb4_pkg.sv | 11 +
 rtl/rr_arb4_if.sv | 29 ++
 rtl/mux2s.sv | 22 ++
 rtl/rr_arb4.sv | 97 +++++++++
 tb/tb_rr_arb4.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/rr_arb4_pkg.sv
// rr_arb4 shared constants and types.
// Channel count, select width and output slot state.
package rr_arb4_pkg;
  localparam int NCH  = 4;
  localparam int SELW = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;
endpackage

// File: rtl/rr_arb4_if.sv
// rr_arb4 port bundle: requester side plus the
// registered valid/ready output slot.
interface rr_arb4_if #(
  parameter int w = 4
);
  import rr_arb4_pkg::*;

  logic [NCH-1:0]  req;
  logic [w-1:0]    d0;
  logic [w-1:0]    d1;
  logic [w-1:0]    d2;
  logic [w-1:0]    d3;
  logic [NCH-1:0]  ack;
  logic [SELW-1:0] s;
  logic [w-1:0]    o;
  logic [SELW-1:0] src;
  logic            ov;
  logic            ordy;

  modport master (
    input  req, d0, d1, d2, d3, ordy,
    output ack, s, o, src, ov
  );

  modport slave (
    output req, d0, d1, d2, d3, ordy,
    input  ack, s, o, src, ov
  );
endinterface

// File: rtl/mux2s.sv
// 4:1 word select driven by a 2-bit index.
// Pure combinational datapath.
module mux2s #(
  parameter int w = 4
) (
  input  logic [1:0]   s,
  input  logic [w-1:0] d0,
  input  logic [w-1:0] d1,
  input  logic [w-1:0] d2,
  input  logic [w-1:0] d3,
  output logic [w-1:0] y
);
  always_comb begin
    y = d0;
    unique case (s)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end
endmodule

// File: rtl/rr_arb4.sv
// Four-channel round-robin arbiter feeding a
// single registered valid/ready output slot.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int w = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_arb4_if.master bus
);
  logic [SELW-1:0] p_q;
  logic [SELW-1:0] p_d;
  logic [SELW-1:0] src_q;
  logic [SELW-1:0] src_d;
  logic [w-1:0]    o_q;
  logic [w-1:0]    o_d;
  slot_t           slot_q;
  slot_t           slot_d;

  logic [SELW-1:0] win;
  logic [SELW-1:0] idx;
  logic            found;
  logic            any_req;
  logic            load;
  logic [NCH-1:0]  ack;
  logic [w-1:0]    mux_y;

  // Rotating priority search starting at the pointer.
  always_comb begin
    win   = p_q;
    idx   = p_q;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = p_q + SELW'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign any_req = |bus.req;
  assign load    = rst_n && (slot_q == EMPTY || bus.ordy)
                   && any_req;
  assign ack     = load ? (NCH'(1) << win) : '0;

  mux2s #(.w(w)) u_mux (
    .s  (win),
    .d0 (bus.d0),
    .d1 (bus.d1),
    .d2 (bus.d2),
    .d3 (bus.d3),
    .y  (mux_y)
  );

  always_comb begin
    slot_d = slot_q;
    o_d    = o_q;
    src_d  = src_q;
    p_d    = p_q;
    if (load) begin
      slot_d = FULL;
      o_d    = mux_y;
      src_d  = win;
      p_d    = win + SELW'(1);
    end else if (slot_q == FULL && bus.ordy) begin
      slot_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= EMPTY;
      o_q    <= '0;
      src_q  <= '0;
    end else begin
      slot_q <= slot_d;
      o_q    <= o_d;
      src_q  <= src_d;
    end
  end

  assign bus.ack = ack;
  assign bus.s   = win;
  assign bus.o   = o_q;
  assign bus.src = src_q;
  assign bus.ov  = (slot_q == FULL);
endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: driver with reference model
// pushes expected words, monitor drains and compares.
module tb_rr_arb4;
  localparam int W = 8;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb4_if #(.w(W)) bus ();

  rr_arb4 #(.w(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  item_t        expq[$];
  int           pm;
  int           tests;
  int           fails;
  logic [W-1:0] dv[4];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check the
  // combinational outputs, update the model at the edge.
  task automatic cycle(input logic r,
                       input logic [3:0] rq,
                       input logic rd);
    int    win;
    bit    found;
    logic  ld;
    logic [3:0] eack;
    item_t it;
    @(negedge clk);
    rst_n    = r;
    bus.req  = rq;
    bus.ordy = rd;
    bus.d0   = dv[0];
    bus.d1   = dv[1];
    bus.d2   = dv[2];
    bus.d3   = dv[3];
    #1;
    if (!r) begin
      expq.delete();
      pm = 0;
      check("rst_o", 32'(bus.o), 32'(0));
      check("rst_src", 32'(bus.src), 32'(0));
    end
    win   = pm;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && rq[(pm + k) % 4]) begin
        win   = (pm + k) % 4;
        found = 1'b1;
      end
    end
    ld   = r && (expq.size() == 0 || rd) && (rq != 4'b0);
    eack = ld ? (4'b0001 << win) : 4'b0000;
    check("ack", 32'(bus.ack), 32'(eack));
    check("s", 32'(bus.s), 32'(win));
    it.ch   = 2'(win);
    it.data = dv[win];
    @(posedge clk);
    #1;
    if (ld) begin
      expq.push_back(it);
      pm = (win + 1) % 4;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expq.delete();
    pm = 0;
    #2;
    check("arst_ov", 32'(bus.ov), 32'(0));
    check("arst_o", 32'(bus.o), 32'(0));
    check("arst_src", 32'(bus.src), 32'(0));
    check("arst_ack", 32'(bus.ack), 32'(0));
    check("arst_s", 32'(bus.s), 32'(0));
  endtask

  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #3;
      check("ov", 32'(bus.ov), 32'(expq.size() > 0));
      if (expq.size() > 0 && bus.ordy) begin
        it = expq.pop_front();
        check("o", 32'(bus.o), 32'(it.data));
        check("src", 32'(bus.src), 32'(it.ch));
      end
    end
  end

  initial begin
    tests    = 0;
    fails    = 0;
    pm       = 0;
    bus.req  = '0;
    bus.ordy = 1'b0;
    bus.d0   = '0;
    bus.d1   = '0;
    bus.d2   = '0;
    bus.d3   = '0;
    for (int i = 0; i < 4; i++) dv[i] = 8'(8'h10 + i);

    repeat (3) cycle(1'b0, 4'hF, 1'b1);
    repeat (5) cycle(1'b1, 4'hF, 1'b1);
    repeat (2) cycle(1'b1, 4'h0, 1'b1);

    cycle(1'b0, 4'h0, 1'b1);
    dv[2] = 8'hA5;
    cycle(1'b1, 4'b0100, 1'b1);
    cycle(1'b1, 4'h0, 1'b1);
    cycle(1'b1, 4'b0011, 1'b1);
    cycle(1'b1, 4'b0011, 1'b1);
    cycle(1'b1, 4'h0, 1'b1);

    for (int i = 0; i < 4; i++) dv[i] = 8'h3C;
    cycle(1'b1, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) dv[i] = 8'(8'h40 + i);
    repeat (5) cycle(1'b1, 4'hF, 1'b0);
    repeat (2) cycle(1'b1, 4'hF, 1'b1);

    cycle(1'b1, 4'hF, 1'b0);
    async_reset();
    repeat (2) cycle(1'b0, 4'hF, 1'b0);
    repeat (2) cycle(1'b1, 4'h0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
      cycle(1'(($urandom % 50) != 0),
            4'($urandom),
            1'(($urandom % 4) != 0));
    end
    repeat (3) cycle(1'b1, 4'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
